// File: rtl/nios_mode_switch_seq.sv
// RX/TX changeover sequencer between the NIOS mode PIO and the RF front-end controls.
// Optional TX dwell watchdog enabled by `define MODE_SEQ_WATCHDOG_EN.
module nios_mode_switch_seq #(
  parameter int MUTE_CYCLES       = 16,
  parameter int RELAY_CYCLES      = 4096,
  parameter int TX_TIMEOUT_CYCLES = 2**26,
  parameter int CNT_W             = 27
) (
  input  logic clk,
  input  logic reset,
  input  logic mode_req,
  output logic rx_mute,
  output logic ptt_relay,
  output logic tx_enable,
  output logic tx_active,
  output logic busy,
  output logic tx_timeout
);

  typedef enum logic [2:0] {
    S_RX       = 3'd0,
    S_MUTE_RX  = 3'd1,
    S_RELAY_TX = 3'd2,
    S_TX       = 3'd3,
    S_TX_OFF   = 3'd4,
    S_RELAY_RX = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] MUTE_LOAD  = CNT_W'(MUTE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RELAY_LOAD = CNT_W'(RELAY_CYCLES - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             req_q;
  logic             wd_expired;
  logic             tx_timeout_reg;

`ifdef MODE_SEQ_WATCHDOG_EN
  localparam logic [CNT_W-1:0] TX_TIMEOUT_LOAD = CNT_W'(TX_TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] tx_cnt_reg, tx_cnt_next;
  logic             tx_timeout_next;

  assign wd_expired = (state_reg == S_TX) && (tx_cnt_reg == '0);

  always_comb begin
    tx_cnt_next     = (tx_cnt_reg == '0) ? '0 : tx_cnt_reg - 1'b1;
    tx_timeout_next = tx_timeout_reg;
    if (state_next == S_TX && state_reg != S_TX)
      tx_cnt_next = TX_TIMEOUT_LOAD;
    if (wd_expired)
      tx_timeout_next = 1'b1;
    else if (state_reg == S_RX && req_q)
      tx_timeout_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_cnt_reg     <= '0;
      tx_timeout_reg <= 1'b0;
    end else begin
      tx_cnt_reg     <= tx_cnt_next;
      tx_timeout_reg <= tx_timeout_next;
    end
  end
`else
  logic unused_tx_timeout_cfg;
  assign unused_tx_timeout_cfg = (TX_TIMEOUT_CYCLES >= 1);
  assign wd_expired     = 1'b0;
  assign tx_timeout_reg = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_RX;
      cnt_reg   <= '0;
      req_q     <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      req_q     <= mode_req;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = (cnt_reg == '0) ? '0 : cnt_reg - 1'b1;
    case (state_reg)
      S_RX: begin
        if (!req_q && !tx_timeout_reg) begin
          state_next = S_MUTE_RX;
          cnt_next   = MUTE_LOAD;
        end
      end
      S_MUTE_RX: begin
        if (req_q) begin
          state_next = S_RELAY_RX;
          cnt_next   = RELAY_LOAD;
        end else if (cnt_reg == '0) begin
          state_next = S_RELAY_TX;
          cnt_next   = RELAY_LOAD;
        end
      end
      S_RELAY_TX: begin
        // Aborting here drops the relay before the TX chain was ever enabled.
        if (req_q) begin
          state_next = S_RELAY_RX;
          cnt_next   = RELAY_LOAD;
        end else if (cnt_reg == '0) begin
          state_next = S_TX;
        end
      end
      S_TX: begin
        if (req_q || wd_expired) begin
          state_next = S_TX_OFF;
          cnt_next   = MUTE_LOAD;
        end
      end
      S_TX_OFF: begin
        if (cnt_reg == '0) begin
          state_next = S_RELAY_RX;
          cnt_next   = RELAY_LOAD;
        end
      end
      S_RELAY_RX: begin
        if (cnt_reg == '0)
          state_next = S_RX;
      end
      default: begin
        state_next = S_RX;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    rx_mute   = 1'b0;
    ptt_relay = 1'b0;
    tx_enable = 1'b0;
    case (state_reg)
      S_MUTE_RX:  rx_mute = 1'b1;
      S_RELAY_TX: begin rx_mute = 1'b1; ptt_relay = 1'b1; end
      S_TX:       begin rx_mute = 1'b1; ptt_relay = 1'b1; tx_enable = 1'b1; end
      S_TX_OFF:   begin rx_mute = 1'b1; ptt_relay = 1'b1; end
      S_RELAY_RX: rx_mute = 1'b1;
      default:    ;
    endcase
  end

  assign tx_active  = (state_reg == S_TX);
  assign busy       = (state_reg != S_RX) && (state_reg != S_TX);
  assign tx_timeout = tx_timeout_reg;

endmodule
